// File: rtl/vec_reduce_dma.sv
// vec_reduce_dma: Avalon-MM vector reduction accelerator; a register slave configures a bus master
// that reduces NUM vectors of SIZE signed words and writes one shifted result word per vector.
module vec_reduce_dma #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        slave_address,
  input  logic              slave_chipselect,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [DATA_W-1:0] slave_writedata,
  output logic [DATA_W-1:0] slave_readdata,
  output logic [31:0]       master_address,
  output logic              master_read,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_waitrequest,
  output logic              irq
);
  localparam int SH_MAX = ACC_W - DATA_W;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RD_A, S_RD_B, S_ACC, S_WR, S_NXT, S_FIN} state_t;
  state_t r_state, w_next;
  logic r_go, r_irq_en, r_done;
  logic [1:0] r_mode;
  logic [31:0] r_src_a, r_src_b, r_dst, r_pa, r_pb, r_pd;
  logic [CNT_W-1:0] r_size, r_num, r_ecnt, r_vcnt, w_ecnt_n, w_vcnt_n;
  logic [5:0] r_shift;
  logic [6:0] w_sh;
  logic [DATA_W-1:0] r_a, r_b, w_res, w_rd;
  logic [ACC_W-1:0] r_acc, w_term;
  logic signed [DATA_W:0] w_d;
  logic [DATA_W:0] w_abs;
  logic [2*DATA_W-1:0] w_sq;
  logic w_idle, w_wr_en;
  assign w_idle   = r_state == S_IDLE;
  assign w_wr_en  = slave_chipselect && slave_write;
  assign w_ecnt_n = r_ecnt + 1'b1;
  assign w_vcnt_n = r_vcnt + 1'b1;
  // a and b are sign-extended by one bit so |a| and |a-b| never overflow
  assign w_d    = {r_a[DATA_W-1], r_a} - (r_mode == 2'd1 ? {r_b[DATA_W-1], r_b} : '0);
  assign w_abs  = w_d[DATA_W] ? -w_d : w_d;
  assign w_sq   = $signed(r_a) * $signed(r_a);
  assign w_term = r_mode[1] ? (r_mode[0] ? {{(ACC_W-DATA_W){r_a[DATA_W-1]}}, r_a} : ACC_W'(w_sq))
                            : ACC_W'(w_abs);
  assign w_sh   = (int'(r_shift) > SH_MAX) ? 7'(SH_MAX) : {1'b0, r_shift};
  assign w_res  = DATA_W'(r_acc >> w_sh);
  assign master_read      = r_state == S_RD_A || r_state == S_RD_B;
  assign master_write     = r_state == S_WR;
  assign master_address   = r_state == S_RD_A ? r_pa : r_state == S_RD_B ? r_pb : r_state == S_WR ? r_pd : '0;
  assign master_writedata = master_write ? w_res : '0;
  assign irq              = r_done & r_irq_en;
  always_comb begin
    w_rd = '0;
    case (slave_address)
      3'd0: w_rd = DATA_W'({r_done, !w_idle, 26'd0, r_irq_en, r_mode, r_go});
      3'd1: w_rd = DATA_W'(r_src_a);
      3'd2: w_rd = DATA_W'(r_src_b);
      3'd3: w_rd = DATA_W'(r_dst);
      3'd4: w_rd = DATA_W'(r_size);
      3'd5: w_rd = DATA_W'(r_num);
      3'd6: w_rd = DATA_W'(r_shift);
      default: w_rd = '0;
    endcase
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (r_go) w_next = (r_size == '0 || r_num == '0) ? S_FIN : S_CLR;
      S_CLR:  w_next = S_RD_A;
      S_RD_A: if (!master_waitrequest) w_next = r_mode == 2'd1 ? S_RD_B : S_ACC;
      S_RD_B: if (!master_waitrequest) w_next = S_ACC;
      S_ACC:  w_next = w_ecnt_n == r_size ? S_WR : S_RD_A;
      S_WR:   if (!master_waitrequest) w_next = S_NXT;
      S_NXT:  w_next = w_vcnt_n == r_num ? S_FIN : S_CLR;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slave_readdata <= '0;
      {r_go, r_irq_en, r_done, r_mode} <= '0;
      {r_src_a, r_src_b, r_dst, r_pa, r_pb, r_pd} <= '0;
      {r_size, r_num, r_ecnt, r_vcnt, r_shift} <= '0;
      {r_a, r_b, r_acc} <= '0;
    end else begin
      if (slave_chipselect && slave_read) slave_readdata <= w_rd;
      if (w_idle && r_go) begin
        r_go   <= 1'b0;
        r_pa   <= r_src_a;
        r_pb   <= r_src_b;
        r_pd   <= r_dst;
        r_vcnt <= '0;
      end
      if (w_wr_en && slave_address == 3'd0) begin
        r_irq_en <= slave_writedata[3];
        if (slave_writedata[31] || (w_idle && slave_writedata[0])) r_done <= 1'b0;
        if (w_idle) begin
          r_mode <= slave_writedata[2:1];
          r_go   <= slave_writedata[0];
        end
      end
      if (w_wr_en && w_idle) begin
        if (slave_address == 3'd1) r_src_a <= 32'(slave_writedata);
        if (slave_address == 3'd2) r_src_b <= 32'(slave_writedata);
        if (slave_address == 3'd3) r_dst   <= 32'(slave_writedata);
        if (slave_address == 3'd4) r_size  <= CNT_W'(slave_writedata);
        if (slave_address == 3'd5) r_num   <= CNT_W'(slave_writedata);
        if (slave_address == 3'd6) r_shift <= slave_writedata[5:0];
      end
      case (r_state)
        S_CLR: begin
          r_acc  <= '0;
          r_ecnt <= '0;
        end
        S_RD_A: if (!master_waitrequest) r_a <= master_readdata;
        S_RD_B: if (!master_waitrequest) r_b <= master_readdata;
        S_ACC: begin
          r_acc  <= r_acc + w_term;
          r_pa   <= r_pa + 32'd4;
          r_pb   <= r_pb + 32'd4;
          r_ecnt <= w_ecnt_n;
        end
        S_NXT: begin
          r_vcnt <= w_vcnt_n;
          r_pd   <= r_pd + 32'd4;
        end
        S_FIN: r_done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_reduce_dma.sv
// tb_vec_reduce_dma: directed bench with a memory model and a write scoreboard for vec_reduce_dma.
module tb_vec_reduce_dma;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [2:0] slave_address;
  logic slave_chipselect, slave_read, slave_write;
  logic [31:0] slave_writedata, slave_readdata;
  logic [31:0] master_address, master_writedata, master_readdata;
  logic master_read, master_write, master_waitrequest, irq;
  logic [31:0] mem [0:1023];
  logic [31:0] exp_a[$], exp_d[$], obs_a[$], obs_d[$], rd_a[$];
  int total = 0, bad = 0, obs_i = 0;
  int stall_viol = 0, n_stall = 0;
  logic p_stall = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  logic [31:0] p_addr = '0, p_wd = '0;
  logic rand_en = 1'b0;

  always #5 clk = ~clk;
  assign master_readdata = mem[master_address[11:2]];

  vec_reduce_dma dut (
    .clk(clk), .reset_n(reset_n),
    .slave_address(slave_address), .slave_chipselect(slave_chipselect),
    .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
    .master_address(master_address), .master_read(master_read), .master_write(master_write),
    .master_writedata(master_writedata), .master_readdata(master_readdata),
    .master_waitrequest(master_waitrequest), .irq(irq)
  );

  initial begin
    master_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #2 master_waitrequest = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (p_stall && {master_address, master_read, master_write, master_writedata} !== {p_addr, p_rd, p_wr, p_wd})
      stall_viol <= stall_viol + 1;
    if ((master_read || master_write) && master_waitrequest) n_stall <= n_stall + 1;
    if (master_read && !master_waitrequest) rd_a.push_back(master_address);
    if (master_write && !master_waitrequest) begin
      obs_a.push_back(master_address);
      obs_d.push_back(master_writedata);
    end
    p_stall <= (master_read || master_write) && master_waitrequest;
    p_addr  <= master_address;
    p_rd    <= master_read;
    p_wr    <= master_write;
    p_wd    <= master_writedata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_chipselect = 1'b1; slave_write = 1'b1; slave_address = a; slave_writedata = d;
    @(negedge clk);
    slave_chipselect = 1'b0; slave_write = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_chipselect = 1'b1; slave_read = 1'b1; slave_address = a;
    @(negedge clk);
    slave_chipselect = 1'b0; slave_read = 1'b0;
    d = slave_readdata;
  endtask

  task automatic setup(input int size, input int num, input int shift);
    wr_reg(3'd1, 32'h100);
    wr_reg(3'd2, 32'h400);
    wr_reg(3'd3, 32'h800);
    wr_reg(3'd4, 32'(size));
    wr_reg(3'd5, 32'(num));
    wr_reg(3'd6, 32'(shift));
  endtask

  task automatic go(input int mode);
    wr_reg(3'd0, 32'h9 | 32'(mode << 1));
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!irq && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(irq), 32'd1);
  endtask

  task automatic check_writes(input string tag);
    logic [31:0] ea, ed;
    chk({tag, "_wrcount"}, 32'(obs_a.size() - obs_i), 32'(exp_a.size()));
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      ed = exp_d.pop_front();
      if (obs_i < obs_a.size()) begin
        chk({tag, "_wraddr"}, obs_a[obs_i], ea);
        chk({tag, "_wrdata"}, obs_d[obs_i], ed);
        obs_i++;
      end
    end
    obs_i = obs_a.size();
  endtask

  function automatic logic [31:0] model(input int mode, input int sh, input int ai, input int bi, input int size);
    longint acc = 0, a, b, d;
    logic [63:0] r;
    for (int e = 0; e < size; e++) begin
      a = longint'($signed(mem[ai + e]));
      b = longint'($signed(mem[bi + e]));
      d = (mode == 1) ? a - b : a;
      if (mode < 2) acc += (d < 0) ? -d : d;
      else if (mode == 2) acc += a * a;
      else acc += a;
    end
    r = 64'(acc >>> ((sh > 32) ? 32 : sh));
    return r[31:0];
  endfunction

  initial begin
    logic [31:0] d;
    int ri, nr, nw, sv, ns, n;
    slave_chipselect = 1'b0; slave_read = 1'b0; slave_write = 1'b0;
    slave_address = '0; slave_writedata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", slave_readdata, 32'd0);
    chk("rst_strobes", {30'd0, master_read, master_write}, 32'd0);
    chk("rst_maddr", master_address, 32'd0);
    chk("rst_mwdata", master_writedata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;

    mem[64] = 32'd5; mem[65] = 32'hFFFFFFF9; mem[66] = 32'h80000000;
    setup(3, 1, 0);
    expect_wr(32'h800, 32'h8000000C);
    go(0);
    @(negedge clk); chk("go_lat1", 32'(master_read), 32'd0);
    @(negedge clk); chk("go_lat2", 32'(master_read), 32'd1);
    wait_done("m0_done");
    check_writes("m0");
    rd_reg(3'd0, d); chk("m0_ctrl", d, 32'h80000008);

    mem[64] = 32'd10; mem[65] = 32'd3; mem[66] = 32'd1; mem[67] = 32'd1;
    mem[256] = 32'd4; mem[257] = 32'd9; mem[258] = 32'd1; mem[259] = 32'hFFFFFFFE;
    setup(2, 2, 0);
    expect_wr(32'h800, 32'd12);
    expect_wr(32'h804, 32'd3);
    ri = rd_a.size();
    go(1);
    rd_reg(3'd0, d); chk("m1_busy", d, 32'h4000000A);
    wait_done("m1_done");
    check_writes("m1");
    chk("m1_rdcount", 32'(rd_a.size() - ri), 32'd8);
    for (int i = 0; i < 8; i++)
      if (ri + i < rd_a.size())
        chk("m1_rdaddr", rd_a[ri + i], ((i % 2) ? 32'h400 : 32'h100) + 32'(4 * (i / 2)));

    mem[64] = 32'd3; mem[65] = 32'hFFFFFFFC;
    setup(2, 1, 0);
    expect_wr(32'h800, 32'd25);
    go(2); wait_done("m2_done"); check_writes("m2");

    mem[64] = 32'hFFFFFFFB; mem[65] = 32'd2;
    setup(2, 1, 0);
    expect_wr(32'h800, 32'hFFFFFFFD);
    go(3); wait_done("m3_done"); check_writes("m3");

    mem[64] = 32'h100;
    setup(1, 1, 4);
    expect_wr(32'h800, 32'h10);
    go(3); wait_done("m3sh_done"); check_writes("m3sh");

    mem[64] = 32'h80000000;
    setup(1, 1, 63);
    expect_wr(32'h800, 32'h40000000);
    go(2); wait_done("clamp_done"); check_writes("clamp");

    for (int i = 0; i < 20; i++) mem[64 + i] = $urandom;
    setup(5, 4, 0);
    for (int v = 0; v < 4; v++) expect_wr(32'h800 + 32'(4 * v), model(0, 0, 64 + 5 * v, 256, 5));
    sv = stall_viol; ns = n_stall;
    rand_en = 1'b1;
    go(0); wait_done("rw_done");
    rand_en = 1'b0;
    check_writes("rw");
    chk("rw_stable", 32'(stall_viol - sv), 32'd0);
    chk("rw_stalled", 32'(n_stall > ns), 32'd1);

    setup(0, 1, 0);
    nr = rd_a.size(); nw = obs_a.size();
    go(0);
    @(negedge clk); chk("z_irq1", 32'(irq), 32'd0);
    @(negedge clk); chk("z_irq2", 32'(irq), 32'd1);
    repeat (3) @(negedge clk);
    chk("z_nostrobe", 32'(rd_a.size() - nr + obs_a.size() - nw), 32'd0);
    wr_reg(3'd0, 32'h80000008);
    chk("z_irqclr", 32'(irq), 32'd0);
    rd_reg(3'd0, d); chk("z_ctrl", d, 32'h00000008);

    mem[64] = 32'd1; mem[65] = 32'd2; mem[66] = 32'd3; mem[67] = 32'd4;
    setup(2, 2, 0);
    expect_wr(32'h800, 32'd3);
    go(0);
    n = 0;
    while (!(master_read && master_address == 32'h108) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("ab_reach", master_address, 32'h108);
    #1 reset_n = 1'b0;
    #1 chk("ab_strobe", {30'd0, master_read, master_write}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), d);
      chk("ab_reg", d, 32'd0);
    end
    check_writes("ab");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
